present_sbox_seq: RTL and testbench
===================================

Name: present_sbox_seq

Overview:
- Upstream driver and collector for the 2-share masked PRESENT sbox (`sbox`, fixed pipeline latency).
- Accepts an unmasked 4-bit nibble over valid/ready and splits it into two Boolean shares with fresh randomness.
- Holds the shares and the refresh bit `r` stable for LATENCY cycles, then captures both output shares.
- Returns the recombined nibble over valid/ready. Used for integration and security-evaluation runs (VCD capture of `sbox` switching).

Parameters:
- LATENCY, 5, number of clk cycles `sbox` needs from stable input shares to valid output shares; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a nibble.
- in_data  input  4  unmasked sbox input; bit3 maps to x0.
- rnd_in  input  5  fresh randomness, sampled on accept; [3:0] = mask m, [4] = refresh bit r.
- sh0_o  output  4  share 0 to sbox; bit3 = x0_0 .. bit0 = x3_0.
- sh1_o  output  4  share 1 to sbox; bit3 = x0_1 .. bit0 = x3_1.
- r_o  output  1  refresh bit to sbox `r`.
- y0_i  input  4  sbox output share 0 = {Y3_0,Y2_0,Y1_0,Y0_0}.
- y1_i  input  4  sbox output share 1 = {Y3_1,Y2_1,Y1_1,Y0_1}.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  4  unmasked result = y0_i ^ y1_i, as captured.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1, out_valid=0, out_data=0, sh0_o=0, sh1_o=0, r_o=0, counter=0. A reset asserted mid-operation aborts the operation immediately, and the in-flight nibble is discarded.
- FSM states: IDLE, HOLD, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge t:
  - register sh0_o = in_data ^ rnd_in[3:0], sh1_o = rnd_in[3:0], r_o = rnd_in[4];
  - load cnt = LATENCY-1; go to HOLD.
- HOLD: in_ready=0. sh0_o, sh1_o and r_o are held bit-stable for exactly LATENCY cycles, with no glitching register writes.
  - Each edge with cnt!=0: cnt decrements.
  - Edge with cnt==0 (edge t+LATENCY): capture out_data = y0_i ^ y1_i; set out_valid=1; clear sh0_o, sh1_o and r_o to 0; go to DONE.
- DONE: in_ready=0; out_data and out_valid are held until out_valid&&out_ready. On that edge, out_valid=0 and the state returns to IDLE. in_ready becomes 1 in the next cycle; there is no same-cycle re-accept.
- LATENCY=1: HOLD lasts one cycle; capture happens on the first edge after accept.
- Throughput: at most one nibble per LATENCY+2 cycles with out_ready tied high.
- in_valid while in_ready=0 is ignored; the upstream must hold in_data until the handshake.
- rnd_in is sampled only on the accept edge; other values are don't-care.
- Unmasked in_data is never driven onto sh0_o or sh1_o. With m=0 the shares degenerate, which is legal but is the caller's responsibility.

Optional Feature:
- Macro PRESENT_SBOX_CHECK_EN.
- When defined:
  - Adds output `chk_err` (1 bit, reset 0).
  - On the capture edge, the recombined value is compared against the golden PRESENT sbox S(in_data), using the in_data registered at accept.
  - Any mismatch sets chk_err sticky until reset.
  - PRESENT sbox S[0..F] = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- When undefined: the chk_err port is absent and no golden-nibble register or table is instantiated.

Decomposition:
- Package present_pkg holds:
  - localparam SBOX table (16x4) for the golden model and bench;
  - state typedef {IDLE,HOLD,DONE};
  - default LATENCY constant 5;
  - nibble/share width constant 4.
- One natural sub-module, present_masker: combinational share split (in_data, m) -> (sh0, sh1), reused by the key-schedule sbox driver.

Test Plan:
- Reset mid-HOLD: accept in_data=3, drop rst_n at cycle 2 -> all outputs 0 immediately, in_ready=1 after release, no out_valid.
- Single op: in_data=0, rnd_in=5'b1_1010, out_ready=1 -> sh0_o=A, sh1_o=A, r_o=1 for exactly 5 cycles; out_valid at edge t+5 with out_data=C.
- Sweep: all 16 inputs with $random rnd_in -> out_data equals S(in_data) every time, e.g. F->2, 5->0, 9->E; chk_err stays 0 with PRESENT_SBOX_CHECK_EN.
- Backpressure: out_ready=0 for 7 cycles after out_valid -> out_data stable, in_ready=0, a second in_valid is not accepted; accept occurs the cycle after the output handshake.
- LATENCY=1 build: in_data=A -> capture one edge after accept, out_data=F.
- Fault injection, macro on: force y0_i bit0 flipped during capture for in_data=1 -> out_data=4, chk_err=1 and it stays 1 through later correct ops.

Source files
------------

// File: rtl/present_pkg.sv
// Shared constants and types for the masked PRESENT sbox driver.
// Holds the golden sbox table, FSM state type and widths.
package present_pkg;

  localparam int W = 4;
  localparam int DEF_LATENCY = 5;

  localparam logic [15:0][W-1:0] SBOX = {
    4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
    4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
  };

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/present_masker.sv
// Boolean 2-share split of a nibble with a fresh mask.
// sh0 carries the masked data, sh1 the mask itself.
module present_masker
  import present_pkg::*;
(
  input  logic [W-1:0] data,
  input  logic [W-1:0] m,
  output logic [W-1:0] sh0,
  output logic [W-1:0] sh1
);

  assign sh0 = data ^ m;
  assign sh1 = m;

endmodule

// File: rtl/present_sbox_seq.sv
// Driver/collector around a 2-share masked PRESENT sbox.
// Define PRESENT_SBOX_CHECK_EN to add the sticky golden-model chk_err.
module present_sbox_seq
  import present_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [4:0]   rnd_in,
  output logic [W-1:0] sh0_o,
  output logic [W-1:0] sh1_o,
  output logic         r_o,
  input  logic [W-1:0] y0_i,
  input  logic [W-1:0] y1_i,
`ifdef PRESENT_SBOX_CHECK_EN
  output logic         chk_err,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  state_t state, state_n;
  logic [3:0] cnt;
  logic acc, cap;
  logic [W-1:0] msh0, msh1, y;

  present_masker u_masker (
    .data (in_data),
    .m    (rnd_in[3:0]),
    .sh0  (msh0),
    .sh1  (msh1)
  );

  assign y = y0_i ^ y1_i;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    acc = 1'b0;
    cap = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          acc = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          cap = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Shares are written only on accept and capture so sbox inputs never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh0_o <= '0;
      sh1_o <= '0;
      r_o <= 1'b0;
      cnt <= 4'd0;
      out_data <= '0;
    end else begin
      if (acc) begin
        sh0_o <= msh0;
        sh1_o <= msh1;
        r_o <= rnd_in[4];
        cnt <= 4'(LATENCY - 1);
      end else if (state == HOLD && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (cap) begin
        out_data <= y;
        sh0_o <= '0;
        sh1_o <= '0;
        r_o <= 1'b0;
      end
    end
  end

`ifdef PRESENT_SBOX_CHECK_EN
  logic [W-1:0] gold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gold <= '0;
      chk_err <= 1'b0;
    end else begin
      if (acc) gold <= SBOX[in_data];
      if (cap && y != gold) chk_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_present_sbox_seq.sv
// Scoreboard bench for present_sbox_seq with a behavioural masked sbox.
// The sbox model only yields correct shares after LATENCY stable cycles.
module tb_present_sbox_seq;
  import present_pkg::*;

  localparam int LAT = DEF_LATENCY;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic [3:0] in_data;
  logic [4:0] rnd_in;
  logic [3:0] sh0_o, sh1_o;
  logic r_o;
  logic [3:0] y0_i, y1_i;
  logic out_valid;
  logic out_ready;
  logic [3:0] out_data;
`ifdef PRESENT_SBOX_CHECK_EN
  logic chk_err;
  logic err_exp = 1'b0;
`endif

  present_sbox_seq #(.LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rnd_in    (rnd_in),
    .sh0_o     (sh0_o),
    .sh1_o     (sh1_o),
    .r_o       (r_o),
    .y0_i      (y0_i),
    .y1_i      (y1_i),
`ifdef PRESENT_SBOX_CHECK_EN
    .chk_err   (chk_err),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Behavioural masked sbox: correct only after LAT-1 stable negedges
  logic [3:0] p_sh0 = '0, p_sh1 = '0;
  int stable = 0;
  logic fault = 1'b0;
  logic [3:0] ym, km;
  always @(negedge clk) begin
    if (sh0_o === p_sh0 && sh1_o === p_sh1) stable = stable + 1;
    else stable = 0;
    p_sh0 = sh0_o;
    p_sh1 = sh1_o;
    km = 4'($urandom);
    ym = SBOX[sh0_o ^ sh1_o];
    if (stable < LAT - 1) ym = ym ^ 4'($urandom_range(1, 15));
    if (fault) ym[0] = ~ym[0];
    y0_i = ym ^ km;
    y1_i = km;
  end

  // out_ready: 0 random, 1 forced high, 2 forced low
  int or_mode = 1;
  always @(negedge clk) begin
    if (or_mode == 0) out_ready = 1'($urandom);
    else if (or_mode == 1) out_ready = 1'b1;
    else out_ready = 1'b0;
  end

  logic [3:0] exp_q[$];
  int acc_q[$];
  int act_acc = -1;
  int last_acc = -1;
  logic [3:0] cur_sh0, cur_sh1;
  logic cur_r;

  // Monitor: pops the scoreboard on every output handshake
  logic pv = 1'b0, p_hs = 1'b0;
  logic [3:0] pdata = '0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid && !pv) begin
        if (acc_q.size() > 0) chk("latency", cyc, acc_q.pop_front() + LAT);
        else chk("unexpected_valid", 1, 0);
      end
      if (pv && !p_hs) begin
        chk("bp_valid_held", out_valid, 1);
        chk("bp_data_held", out_data, pdata);
      end
      if (out_valid) chk("in_ready_busy", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) chk("out_data", out_data, exp_q.pop_front());
        else chk("unexpected_out", 1, 0);
`ifdef PRESENT_SBOX_CHECK_EN
        chk("chk_err", chk_err, err_exp);
`endif
      end
      if (act_acc >= 0 && cyc >= act_acc) begin
        if (cyc < act_acc + LAT) begin
          chk("sh0_hold", sh0_o, cur_sh0);
          chk("sh1_hold", sh1_o, cur_sh1);
          chk("r_hold", r_o, cur_r);
        end else begin
          chk("shares_clr", {sh0_o, sh1_o, r_o}, 0);
          act_acc = -1;
        end
      end
    end
    pv = out_valid;
    p_hs = out_valid && out_ready;
    pdata = out_data;
  end

  task automatic send(input logic [3:0] d, input logic [4:0] rnd);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    rnd_in = rnd;
    for (n = 0; n < 200; n++) begin
      if (in_ready) break;
      @(negedge clk);
      rnd_in = 5'($urandom);
    end
    if (n == 200) begin
      chk("accept_timeout", 1, 0);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(SBOX[d] ^ {3'b0, fault});
    acc_q.push_back(cyc + 1);
    cur_sh0 = d ^ rnd_in[3:0];
    cur_sh1 = rnd_in[3:0];
    cur_r = rnd_in[4];
    act_acc = cyc + 1;
    last_acc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 4'($urandom);
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 300; n++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(negedge clk);
    end
    if (n == 300) chk("drain_timeout", 1, 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_shares"}, {sh0_o, sh1_o, r_o}, 0);
  endtask

  initial begin
    int hs;
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    rnd_in = '0;
    out_ready = 1'b1;
    y0_i = '0;
    y1_i = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // directed single op: shares A/A, r=1, result C
    or_mode = 1;
    send(4'h0, 5'b1_1010);
    drain();

    // reset while holding shares aborts the op
    send(4'h3, 5'($urandom));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle("midhold");
    exp_q.delete();
    acc_q.delete();
    act_acc = -1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", out_valid, 0);
    end
    chk("post_rst_ready", in_ready, 1);

    // sweep of every input nibble with random masks
    or_mode = 0;
    for (int d = 0; d < 16; d++) send(4'(d), 5'($urandom));
    drain();

    // backpressure: hold out_ready low for 7 cycles
    or_mode = 2;
    send(4'($urandom), 5'($urandom));
    for (n = 0; n < 50 && !out_valid; n++) @(negedge clk);
    chk("bp_valid_seen", out_valid, 1);
    hs = 0;
    fork
      send(4'($urandom), 5'($urandom));
      begin
        repeat (7) @(negedge clk);
        or_mode = 1;
        out_ready = 1'b1;
        hs = cyc + 1;
      end
    join
    chk("bp_accept_after_hs", last_acc, hs + 1);
    drain();

    // random traffic
    or_mode = 0;
    for (int i = 0; i < 40; i++) send(4'($urandom), 5'($urandom));
    drain();

`ifdef PRESENT_SBOX_CHECK_EN
    or_mode = 1;
    fault = 1'b1;
    err_exp = 1'b1;
    send(4'h1, 5'($urandom));
    drain();
    fault = 1'b0;
    for (int i = 0; i < 4; i++) send(4'($urandom), 5'($urandom));
    drain();
    chk("chk_err_sticky", chk_err, 1);
`endif

    repeat (3) @(negedge clk);
    chk("end_idle_ready", in_ready, 1);
    chk("end_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
